// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: per-client byte streams plus the shared UART byte-write port
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_data;
    logic [7:0]           uart_data;
    logic                 uart_wr;
    logic                 uart_tx_full;
    modport master (output req_valid, req_data, req_last, uart_tx_full,
                    input  req_ready, uart_data, uart_wr);
    modport slave  (input  req_valid, req_data, req_last, uart_tx_full,
                    output req_ready, uart_data, uart_wr);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin whole-frame arbiter feeding one UART transmit path
module uart_tx_arbiter #(
    parameter int         NUM_REQ  = 4,
    parameter int         MAX_LEN  = 16,
    parameter int         HDR_EN   = 1,
    parameter logic [7:0] HDR_BASE = 8'hA0
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_err
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int LW = $clog2(MAX_LEN + 1);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;
    state_e        state_q, state_d;
    logic [GW-1:0] rr_q, rr_d, grant_q, grant_d, pick, idx;
    logic [LW-1:0] len_q, len_d;
    logic          err_q, err_d, accept, last_g;
    // Scan downward so the lowest offset from rr_q wins
    always_comb begin
        pick = rr_q;
        idx  = rr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_q) + k) % NUM_REQ);
            if (bus.req_valid[idx]) pick = idx;
        end
    end
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        len_d         = len_q;
        err_d         = 1'b0;
        bus.req_ready = '0;
        bus.uart_wr   = 1'b0;
        bus.uart_data = '0;
        last_g        = bus.req_last[grant_q];
        accept        = reset && state_q == DATA && bus.req_valid[grant_q] && !bus.uart_tx_full;
        if (reset && state_q == IDLE && |bus.req_valid) begin
            grant_d = pick;
            len_d   = '0;
            state_d = (HDR_EN != 0) ? HDR : DATA;
        end
        if (reset && state_q == HDR) begin
            bus.uart_wr   = !bus.uart_tx_full;
            bus.uart_data = HDR_BASE + 8'(grant_q);
            state_d       = bus.uart_tx_full ? HDR : DATA;
        end
        if (reset && state_q == DATA) begin
            bus.req_ready[grant_q] = !bus.uart_tx_full;
            bus.uart_wr            = accept;
            bus.uart_data          = bus.req_data[{grant_q, 3'b000} +: 8];
        end
        if (accept) len_d = len_q + LW'(1);
        // A frame hitting MAX_LEN without last is cut; its tail re-arbitrates later
        if (accept && (last_g || len_q == LW'(MAX_LEN - 1))) begin
            state_d = IDLE;
            rr_d    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
            err_d   = !last_g;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end
    assign grant_id  = grant_q;
    assign busy      = reset && state_q != IDLE;
    assign frame_err = err_q;
endmodule
